sha256_msg_schedule: RTL and testbench



---
 rtl/sha256_pkg.sv | 30 +++
 rtl/sched_word_gen.sv | 64 ++++++
 rtl/sha256_msg_schedule.sv | 94 +++++++++
 tb/tb_sha256_msg_schedule.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared widths, sigma rotate/shift amounts and FSM states for the SHA-256 message schedule.
package sha256_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned ROUNDS  = 64;
  localparam int unsigned WINDOW  = 16;
  localparam int unsigned ROUND_W = 6;
  localparam int unsigned LCNT_W  = 4;

  localparam int unsigned S0_ROT_A = 7;
  localparam int unsigned S0_ROT_B = 18;
  localparam int unsigned S0_SHR   = 3;
  localparam int unsigned S1_ROT_A = 17;
  localparam int unsigned S1_ROT_B = 19;
  localparam int unsigned S1_SHR   = 10;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EMIT,
    ST_DONE
  } state_e;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

endpackage

// File: rtl/sched_word_gen.sv
// Combinational W[t+16] generator: sigma functions, two carry-save layers, one CLA add.
module cla4 (
  input  logic [3:0] g_i,
  input  logic [3:0] p_i,
  input  logic       c_i,
  output logic [3:0] sum_o,
  output logic       c_o
);

  logic [3:0] c;

  assign c[0] = c_i;
  assign c[1] = g_i[0] | (p_i[0] & c_i);
  assign c[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & c_i);
  assign c[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
              | (p_i[2] & p_i[1] & p_i[0] & c_i);
  assign c_o  = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
              | (p_i[3] & p_i[2] & p_i[1] & g_i[0])
              | (p_i[3] & p_i[2] & p_i[1] & p_i[0] & c_i);
  assign sum_o = p_i ^ c;

endmodule

module sched_word_gen
  import sha256_pkg::*;
(
  input  word_t w0_i,
  input  word_t w1_i,
  input  word_t w9_i,
  input  word_t w14_i,
  output word_t new_word_o
);

  localparam int unsigned NSLICE = WORD_W / 4;

  word_t sig0, sig1;
  word_t s1, k1, s2, k2;
  word_t g, p;
  logic [NSLICE:0] carry;

  assign sig0 = rotr(w1_i, S0_ROT_A) ^ rotr(w1_i, S0_ROT_B) ^ (w1_i >> S0_SHR);
  assign sig1 = rotr(w14_i, S1_ROT_A) ^ rotr(w14_i, S1_ROT_B) ^ (w14_i >> S1_SHR);

  // Four operands reduced to sum/carry vectors; carries shifted left, MSB carry dropped.
  assign s1 = sig1 ^ w9_i ^ sig0;
  assign k1 = ((sig1 & w9_i) | (sig1 & sig0) | (w9_i & sig0)) << 1;
  assign s2 = s1 ^ k1 ^ w0_i;
  assign k2 = ((s1 & k1) | (s1 & w0_i) | (k1 & w0_i)) << 1;

  assign g        = s2 & k2;
  assign p        = s2 ^ k2;
  assign carry[0] = 1'b0;

  for (genvar i = 0; i < NSLICE; i++) begin : g_slice
    cla4 u_cla4 (
      .g_i   (g[4*i +: 4]),
      .p_i   (p[4*i +: 4]),
      .c_i   (carry[i]),
      .sum_o (new_word_o[4*i +: 4]),
      .c_o   (carry[i+1])
    );
  end

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads M[0..15] and streams W[0..63] over valid/ready.
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [WORD_W-1:0] word_in_i,
  input  logic              word_in_valid_i,
  output logic              word_in_ready_o,
  output logic [WORD_W-1:0] word_out_o,
  output logic              word_out_valid_o,
  input  logic              word_out_ready_i,
  output logic [ROUND_W-1:0] round_o,
  output logic              done_o
);

  state_e              state_q;
  word_t               win_q [WINDOW];
  logic [LCNT_W-1:0]   lcnt_q;
  logic [ROUND_W-1:0]  round_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                done_q;
  word_t               new_word_d;

  sched_word_gen u_gen (
    .w0_i       (win_q[0]),
    .w1_i       (win_q[1]),
    .w9_i       (win_q[9]),
    .w14_i      (win_q[14]),
    .new_word_o (new_word_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lcnt_q      <= '0;
      round_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < WINDOW; i++) win_q[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q    <= ST_LOAD;
            lcnt_q     <= '0;
            in_ready_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (word_in_valid_i) begin
            for (int i = 0; i < WINDOW - 1; i++) win_q[i] <= win_q[i+1];
            win_q[WINDOW-1] <= word_in_i;
            lcnt_q          <= lcnt_q + LCNT_W'(1);
            if (lcnt_q == LCNT_W'(WINDOW - 1)) begin
              state_q     <= ST_EMIT;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              round_q     <= '0;
            end
          end
        end
        ST_EMIT: begin
          // win_q[0] is the presented word; the tail receives W[t+16].
          if (word_out_ready_i) begin
            for (int i = 0; i < WINDOW - 1; i++) win_q[i] <= win_q[i+1];
            win_q[WINDOW-1] <= new_word_d;
            round_q         <= round_q + ROUND_W'(1);
            if (round_q == ROUND_W'(ROUNDS - 1)) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign word_in_ready_o  = in_ready_q;
  assign word_out_o       = win_q[0];
  assign word_out_valid_o = out_valid_q;
  assign round_o          = round_q;
  assign done_o           = done_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Scoreboard bench for sha256_msg_schedule against a direct SHA-256 schedule recurrence.
module tb_sha256_msg_schedule;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] word_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] word_out;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [5:0]  round;
  logic        done;

  sha256_msg_schedule dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start),
    .word_in_i        (word_in),
    .word_in_valid_i  (in_valid),
    .word_in_ready_o  (in_ready),
    .word_out_o       (word_out),
    .word_out_valid_o (out_valid),
    .word_out_ready_i (out_ready),
    .round_o          (round),
    .done_o           (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] w;
    int          r;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] blk [16];
  logic [31:0] got [64];
  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  int          first_valid_cyc = 0;
  int          start_cyc = 0;
  bit          stall_mode = 1'b0;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_expected();
    logic [31:0] w [64];
    for (int t = 0; t < 16; t++) w[t] = blk[t];
    for (int t = 16; t < 64; t++) w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
    for (int t = 0; t < 64; t++) exp_q.push_back('{w: w[t], r: t});
  endtask

  // Monitor: pops the scoreboard on every output handshake, checks stalls and Done.
  initial begin
    bit          exp_done = 1'b0;
    bit          prev_valid = 1'b0;
    bit          prev_ready = 1'b0;
    logic [31:0] prev_w = '0;
    logic [5:0]  prev_r = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        exp_done   = 1'b0;
      end else begin
        if (exp_done) begin
          check("done_pulse", 32'(done), 32'd1);
          exp_done = 1'b0;
        end else if (done) begin
          check("spurious_done", 32'(done), 32'd0);
        end
        if (done) done_cnt++;
        if (prev_valid && !prev_ready) begin
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_word", word_out, prev_w);
          check("stall_round", 32'(round), 32'(prev_r));
        end
        if (out_valid && !prev_valid) first_valid_cyc = cyc;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word: got %h round %0d, required no output", word_out, round);
          end else begin
            e = exp_q.pop_front();
            check("word", word_out, e.w);
            check("round", 32'(round), 32'(e.r));
            got[e.r] = word_out;
            if (e.r == 63) exp_done = 1'b1;
          end
        end
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_w     = word_out;
        prev_r     = round;
      end
    end
  end

  // Output backpressure generator.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  task automatic load_block();
    int  i = 0;
    int  iter = 0;
    bit  hs;
    start     = 1'b1;
    start_cyc = cyc;
    while (i < 16 && iter < 2000) begin
      in_valid = stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      word_in  = blk[i];
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (hs) i++;
      iter++;
    end
    in_valid = 1'b0;
    if (i < 16) begin
      checks++;
      failures++;
      $display("FAIL load_timeout: accepted %0d words, required 16", i);
    end
  endtask

  task automatic wait_done();
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (done_cnt == d0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: no Done within %0d cycles", n);
    end
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_block();
    push_expected();
    load_block();
    wait_done();
  endtask

  task automatic wait_round(input int r);
    int n = 0;
    while (!(out_valid && round == 6'(r)) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!(out_valid && round == 6'(r))) begin
      checks++;
      failures++;
      $display("FAIL round_timeout: round %0d, required %0d", round, r);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_word_out"}, word_out, 32'd0);
    check({tag, "_round"}, 32'(round), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic rand_block();
    for (int t = 0; t < 16; t++) blk[t] = $urandom;
  endtask

  initial begin
    int saved_done;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // "abc" padded block at full rate
    for (int t = 0; t < 16; t++) blk[t] = '0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    run_block();
    check("abc_w0", got[0], 32'h61626380);
    check("abc_w15", got[15], 32'h00000018);
    check("abc_w16", got[16], 32'h61626380);
    check("abc_w17", got[17], 32'h000F0000);

    for (int t = 0; t < 16; t++) blk[t] = 32'h0;
    run_block();
    check("zero_w63", got[63], 32'h0);

    for (int t = 0; t < 16; t++) blk[t] = 32'hFFFFFFFF;
    run_block();
    check("ones_w16_wrap", got[16], 32'h203FFFFC);

    // "abc" again with random input and output stalls
    for (int t = 0; t < 16; t++) blk[t] = '0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    stall_mode = 1'b1;
    run_block();
    stall_mode = 1'b0;
    check("stall_abc_w17", got[17], 32'h000F0000);

    // Start during EMIT is ignored; reset at round 30 aborts the block
    rand_block();
    push_expected();
    load_block();
    wait_round(10);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_round(30);
    saved_done = done_cnt;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_reset_vals("abort");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt), 32'(saved_done));
    check_reset_vals("abort_idle");
    rand_block();
    run_block();

    // Two back-to-back blocks; second W[0] 17 cycles after its Start
    rand_block();
    run_block();
    rand_block();
    run_block();
    check("b2b_latency", 32'(first_valid_cyc - start_cyc), 32'd17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
